// File: rtl/q1_link_receiver.sv
// Consumer end of the stage-A -> stage-C link: masks words at acceptance, buffers them in a
// DEPTH-entry FIFO, and reports fill level plus a saturating producer-stall cycle count.
module q1_link_receiver #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [WIDTH-1:0]           mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             wr, rd, stalled;

    // Handshake flags come only from registered state, so in_ready never sees out_ready.
    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_data  = mem[rd_ptr_q];
    assign level     = level_q;
    assign stall_cnt = stall_cnt_q;

    assign wr      = in_valid & in_ready;
    assign rd      = out_valid & out_ready;
    assign stalled = in_valid & ~in_ready;

    always_ff @(posedge clk) begin
        if (wr && !flush) begin
            mem[wr_ptr_q] <= in_data & mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr && !rd) begin
                level_q <= level_q + LW'(1);
            end else if (rd && !wr) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stalled && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule
